// File: rtl/jzjpcc_hazard_controller.sv
// Decode/execute hazard controller: destination scoreboard, forwarding selects, load-use stalls, redirect flushes.
// Optional stall/flush event counters are enabled with `define JZJPCC_HAZARD_COUNTERS_EN.
module jzjpcc_hazard_controller #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        decode_valid,
  input  logic [4:0]  decode_rs1Addr,
  input  logic [4:0]  decode_rs2Addr,
  input  logic        decode_rs1Used,
  input  logic        decode_rs2Used,
  input  logic [4:0]  decode_rdAddr,
  input  logic        decode_rdWriteEnable,
  input  logic        decode_rdSource,
  input  logic        execute_redirect,
  output logic        stall,
  output logic        bubble,
  output logic        flush,
  output logic [1:0]  forwardRs1Sel,
  output logic [1:0]  forwardRs2Sel,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount,
  output logic        debugState,
  output logic [20:0] debugScoreboard
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rdAddr;
    logic       isLoad;
  } sbEntry_t;

  state_t     state;
  logic [2:0] flushCounter;
  sbEntry_t   exEntry;
  sbEntry_t   memEntry;
  sbEntry_t   wbEntry;

  logic       rs1Live;
  logic       rs2Live;
  logic       rs1ExHit;
  logic       rs2ExHit;
  logic       rs1MemHit;
  logic       rs2MemHit;
  logic       loadUse;
  logic [1:0] rs1SelNext;
  logic [1:0] rs2SelNext;

  always_comb begin
    rs1Live    = decode_valid & decode_rs1Used & (decode_rs1Addr != 5'd0);
    rs2Live    = decode_valid & decode_rs2Used & (decode_rs2Addr != 5'd0);
    rs1ExHit   = rs1Live & exEntry.valid & (exEntry.rdAddr == decode_rs1Addr);
    rs2ExHit   = rs2Live & exEntry.valid & (exEntry.rdAddr == decode_rs2Addr);
    rs1MemHit  = rs1Live & memEntry.valid & (memEntry.rdAddr == decode_rs1Addr);
    rs2MemHit  = rs2Live & memEntry.valid & (memEntry.rdAddr == decode_rs2Addr);
    loadUse    = (rs1ExHit | rs2ExHit) & exEntry.isLoad;
    // Redirect is only honoured in RUN, but FLUSH flushes regardless, so the OR covers both.
    flush      = (state == FLUSH) | execute_redirect;
    stall      = loadUse & ~flush;
    bubble     = flush | stall;
    rs1SelNext = rs1ExHit ? 2'b01 : (rs1MemHit ? 2'b10 : 2'b00);
    rs2SelNext = rs2ExHit ? 2'b01 : (rs2MemHit ? 2'b10 : 2'b00);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= RUN;
      flushCounter  <= 3'd0;
      exEntry       <= '0;
      memEntry      <= '0;
      wbEntry       <= '0;
      forwardRs1Sel <= 2'b00;
      forwardRs2Sel <= 2'b00;
    end else begin
      wbEntry        <= memEntry;
      memEntry       <= exEntry;
      exEntry.valid  <= decode_valid & decode_rdWriteEnable & ~bubble & (decode_rdAddr != 5'd0);
      exEntry.rdAddr <= decode_rdAddr;
      exEntry.isLoad <= decode_rdSource;
      forwardRs1Sel  <= bubble ? 2'b00 : rs1SelNext;
      forwardRs2Sel  <= bubble ? 2'b00 : rs2SelNext;
      // The redirect cycle itself is the first flush cycle, so FLUSH covers the remaining ones.
      case (state)
        RUN: begin
          if (execute_redirect && (FLUSH_CYCLES > 1)) begin
            state        <= FLUSH;
            flushCounter <= 3'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          flushCounter <= flushCounter - 3'd1;
          if (flushCounter <= 3'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef JZJPCC_HAZARD_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stallCount <= 32'd0;
      flushCount <= 32'd0;
    end else begin
      if (stall) stallCount <= stallCount + 32'd1;
      if ((state == RUN) && execute_redirect) flushCount <= flushCount + 32'd1;
    end
  end
`else
  assign stallCount = 32'd0;
  assign flushCount = 32'd0;
`endif

  assign debugState      = state;
  assign debugScoreboard = {exEntry, memEntry, wbEntry};

endmodule

// File: doc/jzjpcc_hazard_controller.md
Name: jzjpcc_hazard_controller

Overview:
Pipeline sequencing controller for the decode->execute boundary of the pipelined core. It keeps a three-entry destination scoreboard covering the execute, memory and writeback stages. From it the block generates:
- forwarding selects for rs1/rs2,
- load-use stalls,
- bubble insertion into the execute interface,
- flushes after a taken branch/jump redirect.

Decode uses its outputs to gate writes into the execute-stage interface (rdWriteEnable, memoryWriteEnable, rdSource).

Parameters:
FLUSH_CYCLES, 2, number of cycles decode is flushed and execute receives bubbles after a redirect (1..7)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
decode_valid  input  1  decode holds a real instruction
decode_rs1Addr  input  5  rs1 register address of decoding instruction
decode_rs2Addr  input  5  rs2 register address of decoding instruction
decode_rs1Used  input  1  instruction reads rs1
decode_rs2Used  input  1  instruction reads rs2
decode_rdAddr  input  5  destination being issued to execute
decode_rdWriteEnable  input  1  issued instruction writes rd
decode_rdSource  input  1  0 = ALU result, 1 = memory load
execute_redirect  input  1  taken branch/jump resolved in execute this cycle
stall  output  1  hold fetch PC and decode register
bubble  output  1  decode must issue a NOP into execute (all write enables 0)
flush  output  1  invalidate fetch/decode contents
forwardRs1Sel  output  2  00 register file, 01 memory-stage ALU result, 10 writeback value
forwardRs2Sel  output  2  same encoding for rs2
stallCount  output  32  load-use stall cycles (optional feature)
flushCount  output  32  redirects accepted (optional feature)

Behaviour:
- Reset (reset==0 at clock edge):
  - all scoreboard entries invalid;
  - FSM returns to RUN, flush counter cleared;
  - outputs stall=0, bubble=0, flush=0, forwardRs1Sel/forwardRs2Sel=00, counters 0.
  - Reset asserted mid-flush or mid-stall aborts it immediately.
- Scoreboard entries EX, MEM, WB each hold {valid, rdAddr, isLoad}. Every cycle: WB<=MEM, MEM<=EX.
  - EX<={decode_valid & decode_rdWriteEnable & !stall & !bubble & rdAddr!=0, decode_rdAddr, decode_rdSource}.
  - Otherwise EX<=invalid.
- Hazard check (combinational on decode inputs, per used source with address != 0):
  - match EX valid && isLoad -> load-use: stall=1, bubble=1 this cycle.
  - match EX valid && !isLoad -> select 01.
  - else match MEM valid -> select 10.
  - else 00.
  - The newest entry (EX) has priority over MEM.
  - Matches against WB need no forwarding; the register file is write-first.
- Forward selects are registered: the value computed while an instruction sits in decode (and is not stalled) appears on forwardRsXSel during the cycle it is in execute.
  - While stalled or bubbled, the registered selects load 00.
- Load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, so the consumer gets select 10.
- FSM states:
  - RUN: execute_redirect=1 -> FLUSH, counter<=FLUSH_CYCLES-1, with flush=1 and bubble=1 asserted in the same cycle.
  - FLUSH: flush=1, bubble=1, stall=0. Counter decrements each cycle; returns to RUN on the cycle after the counter reaches 0. execute_redirect is ignored in FLUSH.
- Simultaneous events:
  - redirect and load-use in the same cycle: flush wins, stall=0, bubble=1.
  - decode_valid=0: no stall, selects 00.
- Outputs stall/bubble/flush are combinational from the FSM state and the current scoreboard. No other latency.

Optional Feature:
JZJPCC_HAZARD_COUNTERS_EN.
- Defined: stallCount increments on every cycle with stall=1; flushCount increments on every RUN->FLUSH transition. Both are 32-bit, wrap at 2^32-1 -> 0, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
1. ALU writes x5, next instruction reads rs1=x5 -> no stall; forwardRs1Sel=01 in consumer's execute cycle.
2. Load to x7, immediate consumer reads rs2=x7 -> exactly one cycle stall=1, bubble=1; then forwardRs2Sel=10, with one bubble seen in the MEM entry.
3. Writer of x0 followed by reader of x0 -> no stall, selects 00.
4. execute_redirect pulse, FLUSH_CYCLES=2 -> flush=1, bubble=1 for 2 cycles, then RUN. A second redirect pulse in cycle 2 is ignored; flushCount=1.
5. Load-use hazard present while execute_redirect=1 -> stall=0, flush=1; stallCount unchanged.
6. reset driven low during FLUSH and during a stall -> next edge: all outputs 0, scoreboard empty, and a subsequent dependent pair shows no stale forwarding.
